// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, and an always-on view of $v0.
module mips_register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg_1,
    input  logic [4:0]  read_reg_2,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    output logic [31:0] read_data_v0
);
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // $0 has no storage at all, so nothing can ever make it read nonzero
    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk) begin
            if (reset)
                q <= '0;
            else if (write_enable && (write_reg == 5'(i)))
                q <= write_data;
        end

        assign regs[i] = q;
    end

    // Reads see only committed state; there is deliberately no write bypass
    assign read_data_1  = regs[read_reg_1];
    assign read_data_2  = regs[read_reg_2];
    assign read_data_v0 = regs[2];

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file with hand-computed expectations.
module tb_mips_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] read_data_v0;

    int n_chk  = 0;
    int n_pass = 0;

    mips_register_file dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_reg_1   (read_reg_1),
        .read_reg_2   (read_reg_2),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2),
        .read_data_v0 (read_data_v0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; write_enable = 1'b0; write_reg = '0; write_data = '0;
        read_reg_1 = 5'd16; read_reg_2 = 5'd20;
        #2;
        tick();
        chk("rst_rd1", read_data_1, 32'd0);
        chk("rst_rd2", read_data_2, 32'd0);
        chk("rst_v0", read_data_v0, 32'd0);

        // single write / read
        reset = 1'b0; write_enable = 1'b1; write_reg = 5'd16; write_data = 32'd1234567;
        tick();
        write_enable = 1'b0;
        #1 chk("wr16_rd1", read_data_1, 32'd1234567);
        tick();
        chk("wr16_hold", read_data_1, 32'd1234567);

        // dual read ports
        write_enable = 1'b1; write_reg = 5'd20; write_data = 32'd7654321;
        read_reg_1 = 5'd16; read_reg_2 = 5'd20;
        tick();
        write_enable = 1'b0;
        #1;
        chk("dual_rd1", read_data_1, 32'd1234567);
        chk("dual_rd2", read_data_2, 32'd7654321);

        // mid-operation reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("clr_rd1", read_data_1, 32'd0);
        chk("clr_rd2", read_data_2, 32'd0);
        chk("clr_v0", read_data_v0, 32'd0);

        // $0 hardwired
        write_enable = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
        read_reg_1 = 5'd0; read_reg_2 = 5'd0;
        tick();
        write_enable = 1'b0;
        #1;
        chk("r0_rd1", read_data_1, 32'd0);
        chk("r0_rd2", read_data_2, 32'd0);

        // $v0 port, then reset beats simultaneous write
        write_enable = 1'b1; write_reg = 5'd2; write_data = 32'hDEAD_BEEF;
        read_reg_1 = 5'd0; read_reg_2 = 5'd0;
        tick();
        write_enable = 1'b0;
        #1 chk("v0_wr", read_data_v0, 32'hDEAD_BEEF);
        reset = 1'b1; write_enable = 1'b1; write_reg = 5'd2; write_data = 32'd5;
        tick();
        reset = 1'b0; write_enable = 1'b0;
        #1 chk("v0_rst_prio", read_data_v0, 32'd0);

        // no bypass, write_enable gating
        write_enable = 1'b1; write_reg = 5'd7; write_data = 32'h11;
        tick();
        write_data = 32'h22; read_reg_2 = 5'd7;
        #1 chk("nobypass", read_data_2, 32'h11);
        tick();
        write_enable = 1'b0; write_data = 32'h33;
        #1 chk("r7_new", read_data_2, 32'h22);
        tick();
        chk("r7_we0", read_data_2, 32'h22);
        read_reg_1 = 5'd7;
        #1;
        chk("same_rd1", read_data_1, 32'h22);
        chk("same_rd2", read_data_2, 32'h22);
        chk("v0_untouched", read_data_v0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- General-purpose register file for the MIPS-compatible CPU core: 32 registers of 32 bits each.
- Two combinational read ports feed the ALU operand path; one synchronous write port serves writeback.
- A dedicated always-on read of $v0 (register 2) is exported for result observation and debug.
- Register $0 is hardwired to zero.

Parameters:
- None. Widths are fixed: 32 registers, 32-bit data, 5-bit register addresses.

Ports:
- clk  input  1  system clock; all state changes occur on the rising edge
- reset  input  1  synchronous, active-high; clears all registers
- write_enable  input  1  commit write_data to write_reg at the rising edge
- write_reg  input  5  destination register index
- write_data  input  32  data to write
- read_reg_1  input  5  read port 1 register index
- read_reg_2  input  5  read port 2 register index
- read_data_1  output  32  contents of register read_reg_1
- read_data_2  output  32  contents of register read_reg_2
- read_data_v0  output  32  contents of register 2 ($v0), always driven

Behaviour:
- Storage: regs[0..31], 32 bits each.
- Reset: synchronous, active-high, sampled at the rising edge of clk.
  - When reset=1 at an edge, all 32 registers become 0.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Asserting reset mid-operation clears everything on that edge, regardless of prior state.
- Outputs have no reset value of their own. They reflect register contents, so all outputs read 0 after the reset edge.
- Write: at a rising edge with reset=0 and write_enable=1, regs[write_reg] <= write_data.
  - A write to index 0 is ignored; $0 always reads 0.
  - write_enable=0 leaves all registers unchanged.
- Read: purely combinational, with zero-cycle latency from address to data.
  - read_data_1 = regs[read_reg_1]; read_data_2 = regs[read_reg_2]; read_data_v0 = regs[2].
  - A written value is visible on the read ports immediately after the rising edge that commits it, within the same clock period.
- No write-to-read bypass. Before the committing edge, reading the register being written returns the old value.
- Both read ports may address the same register, or the write target, simultaneously without conflict.
- Reading index 0 on any port returns 0x00000000.
- Unknown or undriven read addresses are not required to produce defined data. Benches must drive the addresses before checking.
- Single clock domain. No handshakes, no stalls, no internal state machine.

Test Plan:
- Reset then single write/read: assert reset for one edge. Then reset=0, write_enable=1, write_reg=16, write_data=1234567, read_reg_1=16, one edge. After the edge, drop write_enable; read_data_1 = 1234567. One more edge with write_enable=0; value is still 1234567.
- Dual read ports: write_reg=20, write_data=7654321, write_enable=1, read_reg_1=16, read_reg_2=20, one edge. Then read_data_1=1234567 and read_data_2=7654321.
- Reset clears state: after the above, reset=1 for one edge. read_data_1=0 and read_data_2=0 for indices 16 and 20; read_data_v0=0.
- $0 hardwired: write_enable=1, write_reg=0, write_data=0xFFFFFFFF, one edge. read_reg_1=0 gives read_data_1=0.
- $v0 port and reset priority:
  - Write 0xDEADBEEF to register 2: read_data_v0=0xDEADBEEF with no read address needed.
  - Then reset=1 together with write_enable=1, write_reg=2, write_data=5, one edge: read_data_v0=0.
- No bypass and write_enable gating:
  - Before the edge, register 7 holds 0x11 and a pending write of 0x22 targets it: read_data_2 (read_reg_2=7) = 0x11. After the edge it reads 0x22.
  - With write_enable=0 and write_data=0x33, a further edge leaves it at 0x22.
